// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CPU = 2'd1,
    ST_OWN_LDR = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  function automatic int hold_width(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU and loader/debug
// ports time-share it under a registered owner FSM with a bounded hold time.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  input  logic              ldr_req_i,
  input  logic              ldr_wr_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  output logic              ldr_gnt_o,
  output logic [DATA_W-1:0] ldr_rdata_o,
  output logic              ldr_rvalid_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [DATA_W-1:0] dm_datain_o,
  output logic              dm_memwr_o,
  output logic              dm_memtoreg_o,
  input  logic [DATA_W-1:0] dm_dataout_i
);

  localparam int              HOLD_W    = hold_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                ldr_rvalid_q, ldr_rvalid_d;
  logic                cpu_beat_s, ldr_beat_s;

  assign cpu_gnt_o    = (state_q == ST_OWN_CPU);
  assign ldr_gnt_o    = (state_q == ST_OWN_LDR);
  assign cpu_rdata_o  = cpu_rdata_q;
  assign ldr_rdata_o  = ldr_rdata_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign ldr_rvalid_o = ldr_rvalid_q;

  // A beat needs both ownership and a live request; reset suppresses it so no write escapes.
  assign cpu_beat_s = cpu_gnt_o & cpu_req_i & ~reset_i;
  assign ldr_beat_s = ldr_gnt_o & ldr_req_i & ~reset_i;

  // Owner selection: ties from IDLE go to the port that did not own last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i && ldr_req_i) begin
          state_d = (last_q == OWN_CPU) ? ST_OWN_LDR : ST_OWN_CPU;
        end else if (cpu_req_i) begin
          state_d = ST_OWN_CPU;
        end else if (ldr_req_i) begin
          state_d = ST_OWN_LDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_CPU: begin
        if (ldr_req_i && (hold_q == HOLD_LAST)) begin
          state_d = ST_OWN_LDR;
        end else if (cpu_req_i) begin
          state_d = ST_OWN_CPU;
        end else if (ldr_req_i) begin
          state_d = ST_OWN_LDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_LDR: begin
        if (cpu_req_i && (hold_q == HOLD_LAST)) begin
          state_d = ST_OWN_CPU;
        end else if (ldr_req_i) begin
          state_d = ST_OWN_LDR;
        end else if (cpu_req_i) begin
          state_d = ST_OWN_CPU;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hold counter and last-owner tracking.
  always_comb begin
    hold_d = '0;
    last_d = last_q;
    if ((state_q != ST_IDLE) && (state_d == state_q)) begin
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HOLD_W'(1);
    end else begin
      hold_d = '0;
    end
    case (state_q)
      ST_OWN_CPU: last_d = OWN_CPU;
      ST_OWN_LDR: last_d = OWN_LDR;
      default:    last_d = last_q;
    endcase
  end

  // Memory pin mux: only the owner's beat reaches the memory, otherwise all zero.
  always_comb begin
    dm_addr_o     = '0;
    dm_datain_o   = '0;
    dm_memwr_o    = 1'b0;
    dm_memtoreg_o = 1'b0;
    if (cpu_beat_s) begin
      dm_addr_o     = cpu_addr_i;
      dm_datain_o   = cpu_wdata_i;
      dm_memwr_o    = cpu_wr_i;
      dm_memtoreg_o = ~cpu_wr_i;
    end else if (ldr_beat_s) begin
      dm_addr_o     = ldr_addr_i;
      dm_datain_o   = ldr_wdata_i;
      dm_memwr_o    = ldr_wr_i;
      dm_memtoreg_o = ~ldr_wr_i;
    end else begin
      dm_addr_o     = '0;
      dm_datain_o   = '0;
      dm_memwr_o    = 1'b0;
      dm_memtoreg_o = 1'b0;
    end
  end

  // Read-data capture; rdata holds until the same port's next read beat.
  always_comb begin
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    cpu_rvalid_d = 1'b0;
    ldr_rvalid_d = 1'b0;
    if (cpu_beat_s && !cpu_wr_i) begin
      cpu_rdata_d  = dm_dataout_i;
      cpu_rvalid_d = 1'b1;
    end else begin
      cpu_rvalid_d = 1'b0;
    end
    if (ldr_beat_s && !ldr_wr_i) begin
      ldr_rdata_d  = dm_dataout_i;
      ldr_rvalid_d = 1'b1;
    end else begin
      ldr_rvalid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      last_q       <= OWN_LDR;
      hold_q       <= '0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter with a 1024-word data memory attached; read data is
// predicted from a shadow copy of memory and checked through per-port queues.
module tb_dm_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_wr, ldr_req, ldr_wr;
  logic [9:0]  cpu_addr, ldr_addr;
  logic [31:0] cpu_wdata, ldr_wdata;
  logic        cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid;
  logic [31:0] cpu_rdata, ldr_rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_datain, dm_dataout;
  logic        dm_memwr, dm_memtoreg;

  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];

  int checks = 0;
  int errors = 0;

  logic [31:0] q_c[$];
  logic [31:0] q_l[$];
  logic        pend_c = 1'b0;
  logic        pend_l = 1'b0;
  logic [31:0] exp_rd_c = 32'h0;
  logic [31:0] exp_rd_l = 32'h0;

  typedef struct {
    logic       cr;
    logic       lr;
    logic [9:0] ca;
    logic [9:0] la;
    logic       eg_c;
    logic       eg_l;
  } vec_t;
  vec_t tbl [15];

  dm_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rdata_o(cpu_rdata), .cpu_rvalid_o(cpu_rvalid),
    .ldr_req_i(ldr_req), .ldr_wr_i(ldr_wr), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
    .ldr_gnt_o(ldr_gnt), .ldr_rdata_o(ldr_rdata), .ldr_rvalid_o(ldr_rvalid),
    .dm_addr_o(dm_addr), .dm_datain_o(dm_datain), .dm_memwr_o(dm_memwr),
    .dm_memtoreg_o(dm_memtoreg), .dm_dataout_i(dm_dataout)
  );

  assign dm_dataout = dm_memtoreg ? mem[dm_addr] : 32'h0;

  always @(posedge clk) begin
    if (dm_memwr) mem[dm_addr] <= dm_datain;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic run_cycle(input logic cr, input logic cw, input logic [9:0] ca, input logic [31:0] cd,
                           input logic lr, input logic lw, input logic [9:0] la, input logic [31:0] ld,
                           input logic eg_c, input logic eg_l, input string tag);
    logic        beat_c, beat_l;
    logic [9:0]  e_addr;
    logic [31:0] e_din;
    logic        e_wr, e_rd;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
    ldr_req = lr; ldr_wr = lw; ldr_addr = la; ldr_wdata = ld;
    @(negedge clk);
    chk({tag, "_gnt_cpu"}, 32'(cpu_gnt), 32'(eg_c));
    chk({tag, "_gnt_ldr"}, 32'(ldr_gnt), 32'(eg_l));
    beat_c = eg_c & cr;
    beat_l = eg_l & lr;
    e_addr = beat_c ? ca : (beat_l ? la : 10'h0);
    e_din  = beat_c ? cd : (beat_l ? ld : 32'h0);
    e_wr   = beat_c ? cw : (beat_l ? lw : 1'b0);
    e_rd   = beat_c ? ~cw : (beat_l ? ~lw : 1'b0);
    chk({tag, "_dm_addr"}, 32'(dm_addr), 32'(e_addr));
    chk({tag, "_dm_datain"}, dm_datain, e_din);
    chk({tag, "_dm_memwr"}, 32'(dm_memwr), 32'(e_wr));
    chk({tag, "_dm_memtoreg"}, 32'(dm_memtoreg), 32'(e_rd));
    chk({tag, "_rvalid_cpu"}, 32'(cpu_rvalid), 32'(pend_c));
    chk({tag, "_rvalid_ldr"}, 32'(ldr_rvalid), 32'(pend_l));
    if (pend_c && q_c.size() > 0) exp_rd_c = q_c.pop_front();
    if (pend_l && q_l.size() > 0) exp_rd_l = q_l.pop_front();
    chk({tag, "_rdata_cpu"}, cpu_rdata, exp_rd_c);
    chk({tag, "_rdata_ldr"}, ldr_rdata, exp_rd_l);
    pend_c = beat_c & ~cw;
    pend_l = beat_l & ~lw;
    if (pend_c) q_c.push_back(shadow[ca]);
    if (pend_l) q_l.push_back(shadow[la]);
    if (beat_c && cw) shadow[ca] = cd;
    if (beat_l && lw) shadow[la] = ld;
  endtask

  task automatic do_reset(input int n, input logic cr, input logic cw, input logic [9:0] ca,
                          input logic [31:0] cd, input logic lr);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
      ldr_req = lr; ldr_wr = 1'b0; ldr_addr = 10'h0; ldr_wdata = 32'h0;
      @(negedge clk);
      chk("rst_memwr", 32'(dm_memwr), 32'h0);
      chk("rst_memtoreg", 32'(dm_memtoreg), 32'h0);
      chk("rst_addr", 32'(dm_addr), 32'h0);
      chk("rst_datain", dm_datain, 32'h0);
      if (i > 0) begin
        chk("rst_gnt_cpu", 32'(cpu_gnt), 32'h0);
        chk("rst_gnt_ldr", 32'(ldr_gnt), 32'h0);
        chk("rst_rvalid_cpu", 32'(cpu_rvalid), 32'h0);
        chk("rst_rvalid_ldr", 32'(ldr_rvalid), 32'h0);
        chk("rst_rdata_cpu", cpu_rdata, 32'h0);
        chk("rst_rdata_ldr", ldr_rdata, 32'h0);
      end
    end
    pend_c = 1'b0;
    pend_l = 1'b0;
    q_c.delete();
    q_l.delete();
    exp_rd_c = 32'h0;
    exp_rd_l = 32'h0;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 10'h0; cpu_wdata = 32'h0;
    ldr_req = 1'b0; ldr_wr = 1'b0; ldr_addr = 10'h0; ldr_wdata = 32'h0;

    // Tie pattern with continuous requests and MAX_HOLD=4: CPU x4, LDR x4, CPU x4.
    for (int i = 0; i < 15; i++) begin
      tbl[i].cr   = (i <= 12);
      tbl[i].lr   = (i <= 12);
      tbl[i].ca   = 10'(i);
      tbl[i].la   = 10'(15 - i);
      tbl[i].eg_c = ((i >= 1) && (i <= 4)) || ((i >= 9) && (i <= 12));
      tbl[i].eg_l = ((i >= 5) && (i <= 8)) || (i == 13);
    end

    // Reset with both ports requesting.
    do_reset(2, 1'b1, 1'b0, 10'h0, 32'h0, 1'b1);

    // CPU only: write then back-to-back read of 0x010.
    run_cycle(1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, "cpu_w_req");
    run_cycle(1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, "cpu_w_beat");
    run_cycle(1'b1, 1'b0, 10'h010, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, "cpu_r_beat");
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, "cpu_r_done");
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, "cpu_idle");
    chk("cpu_rdata_beef", cpu_rdata, 32'hDEADBEEF);

    // Loader fills 0x000..0x00F with addr*3, then CPU reads 0x005.
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 10'h0, 32'h0, 1'b0, 1'b0, "ldr_req");
    for (int a = 0; a < 16; a++) begin
      run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 10'(a), 32'(a * 3), 1'b0, 1'b1, "ldr_fill");
    end
    run_cycle(1'b1, 1'b0, 10'h005, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b1, "ldr_dead");
    run_cycle(1'b1, 1'b0, 10'h005, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, "cpu_rd5");
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, "cpu_rd5_done");
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, "fill_idle");
    chk("cpu_rdata_0f", cpu_rdata, 32'h0000000F);

    // Fresh reset, then the tie/hold table.
    do_reset(1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      run_cycle(tbl[i].cr, 1'b0, tbl[i].ca, 32'h0, tbl[i].lr, 1'b0, tbl[i].la, 32'h0,
                tbl[i].eg_c, tbl[i].eg_l, $sformatf("tie%0d", i));
    end

    // Owner drops request while granted: dead cycle, then the waiting port.
    run_cycle(1'b1, 1'b0, 10'h002, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, "drop_req");
    run_cycle(1'b1, 1'b0, 10'h002, 32'h0, 1'b1, 1'b0, 10'h009, 32'h0, 1'b1, 1'b0, "drop_cbeat");
    run_cycle(1'b0, 1'b1, 10'h002, 32'h55, 1'b1, 1'b0, 10'h009, 32'h0, 1'b1, 1'b0, "drop_cdead");
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 10'h009, 32'h0, 1'b0, 1'b1, "drop_lbeat");
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b1, 10'h009, 32'h77, 1'b0, 1'b1, "drop_ldead");
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, "drop_idle");

    // Reset lands on a CPU write beat to 0x3FF; the old value must survive.
    run_cycle(1'b1, 1'b1, 10'h3FF, 32'h1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, "rw_req");
    run_cycle(1'b1, 1'b1, 10'h3FF, 32'h1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, "rw_beat1");
    do_reset(1, 1'b1, 1'b1, 10'h3FF, 32'h2, 1'b0);
    run_cycle(1'b1, 1'b0, 10'h3FF, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, "rb_req");
    run_cycle(1'b1, 1'b0, 10'h3FF, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, "rb_beat");
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, "rb_done");
    run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, "rb_idle");
    chk("rst_write_blocked", cpu_rdata, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
